scan_chain_controller: RTL

Host-side initiator for the processor's serial scan chain. Accepts a byte stream over a valid/ready interface, shifts it bit-serially into the chain via `scan_enable`/`scan_in`, and captures the bits emerging on `scan_out` into a returned byte stream, so a full program/state image is loaded and the previous image read back in one pass. Sits between the chip's I/O port logic and `accumulator_microcontroller`. It owns `proc_en`, so the processor never executes while the chain is moving.

---
 rtl/scan_ctrl_pkg.sv | 16 +
 rtl/scan_byte_shifter.sv | 60 ++++++
 rtl/scan_chain_controller.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan-chain controller.
// Holds the FSM state enum, default chain length and byte width.
package scan_ctrl_pkg;

  localparam int CHAIN_LEN_DEF = 280;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_EMIT,
    S_DONE
  } scan_state_t;

endpackage

// File: rtl/scan_byte_shifter.sv
// Per-byte shift/capture pair for the scan chain controller.
// Ports: load/load_data latch a byte; shift steps one bit; scan_in
// drives the chain head; scan_out feeds capture (SCAN_READBACK_EN);
// bits_done marks the 8th shift; cap_aligned is the captured byte
// after this shift, right-aligned for partial bytes.
module scan_byte_shifter
  import scan_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              scan_out,
  output logic              scan_in,
  output logic              bits_done,
  output logic [BYTE_W-1:0] cap_aligned
);

  logic [BYTE_W-1:0] sh_q;
  logic [3:0]        bcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      bcnt_q <= '0;
    end else if (load) begin
      sh_q   <= load_data;
      bcnt_q <= '0;
    end else if (shift) begin
      sh_q   <= {1'b0, sh_q[BYTE_W-1:1]};
      bcnt_q <= bcnt_q + 4'd1;
    end
  end

  assign scan_in   = sh_q[0];
  assign bits_done = (bcnt_q == 4'd7);

`ifdef SCAN_READBACK_EN
  logic [BYTE_W-1:0] cap_q;
  logic [BYTE_W-1:0] cap_nxt;

  assign cap_nxt = {scan_out, cap_q[BYTE_W-1:1]};

  always_ff @(posedge clk) begin
    if (rst)
      cap_q <= '0;
    else if (shift)
      cap_q <= cap_nxt;
  end

  // After n shifts the bits sit in [7:8-n]; drop the stale low bits.
  assign cap_aligned = cap_nxt >> (4'd7 - bcnt_q);
`else
  logic unused_scan;
  assign unused_scan = scan_out;
  assign cap_aligned = '0;
`endif

endmodule

// File: rtl/scan_chain_controller.sv
// Host-side scan-chain initiator: byte stream in, bit-serial chain
// shift, captured byte stream out. Owns proc_en so the processor
// is stopped whenever the chain moves.
// Ports: clk/rst, start/run/busy/done, in_* and out_* valid/ready
// byte streams, scan_enable/scan_in/scan_out chain, proc_en, halt.
// Build option: SCAN_READBACK_EN enables capture and the EMIT state.
module scan_chain_controller
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  output logic              busy,
  output logic              done,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              scan_enable,
  output logic              scan_in,
  input  logic              scan_out,
  output logic              proc_en,
  input  logic              halt
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LEN_M1 = CW'(CHAIN_LEN - 1);

  scan_state_t       state_q;
  logic [CW-1:0]     len_q;
  logic              busy_q;
  logic              done_q;
  logic              se_q;
  logic              idle_q;
  logic              load;
  logic              shift;
  logic              bits_done;
  logic              last_bit;
  logic [BYTE_W-1:0] cap_aligned;

  assign load     = (state_q == S_LOAD) && in_valid;
  assign shift    = (state_q == S_SHIFT);
  assign last_bit = bits_done || (len_q == LEN_M1);

  scan_byte_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .shift       (shift),
    .load_data   (in_data),
    .scan_out    (scan_out),
    .scan_in     (scan_in),
    .bits_done   (bits_done),
    .cap_aligned (cap_aligned)
  );

`ifdef SCAN_READBACK_EN
  logic [BYTE_W-1:0] out_data_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      se_q    <= 1'b0;
      idle_q  <= 1'b0;
`ifdef SCAN_READBACK_EN
      out_data_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          idle_q <= 1'b1;
          if (start) begin
            state_q <= S_LOAD;
            len_q   <= '0;
            busy_q  <= 1'b1;
            idle_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            state_q <= S_SHIFT;
            se_q    <= 1'b1;
          end
        end
        S_SHIFT: begin
          len_q <= len_q + CW'(1);
          if (last_bit) begin
            se_q <= 1'b0;
`ifdef SCAN_READBACK_EN
            state_q    <= S_EMIT;
            out_data_q <= cap_aligned;
`else
            if (len_q == LEN_M1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_LOAD;
            end
`endif
          end
        end
`ifdef SCAN_READBACK_EN
        S_EMIT: begin
          if (out_ready) begin
            if (len_q == CW'(CHAIN_LEN)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          idle_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign scan_enable = se_q;
  assign in_ready    = (state_q == S_LOAD);
  // idle_q is low through reset so run cannot reach proc_en then.
  assign proc_en     = idle_q & run;

  logic unused_in;
`ifdef SCAN_READBACK_EN
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = out_data_q;
  assign unused_in = halt;
`else
  assign out_valid = 1'b0;
  assign out_data  = '0;
  assign unused_in = ^{halt, out_ready, cap_aligned};
`endif

endmodule
